retire_buffered: RTL and testbench

Parametrised last pipeline stage with a posted store buffer. It filters instructions by tag (kill on mismatch) and performs register write-back with load byte/half extraction. It resolves jumps and branch mispredictions, and raises ECALL/EBREAK/illegal and address-misaligned exceptions, MRET and interrupt acknowledge. Retired stores drain to data memory through a DEPTH-entry FIFO with a req/ready handshake. It also keeps a retired-instruction counter.

---
 rtl/retire_buffered_if.sv | 25 ++
 rtl/retire_buffered.sv | 225 ++++++++++++++++++++++
 tb/tb_retire_buffered.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_buffered_if.sv
// Store-buffer drain port: head-of-queue request towards data memory.
// master drives req/addr/be/data, slave returns ready.
interface retire_buffered_if;
    logic        mem_req_o;
    logic        mem_ready_i;
    logic [31:0] mem_write_address_o;
    logic [3:0]  mem_write_enable_o;
    logic [31:0] mem_data_o;

    modport master (
        output mem_req_o,
        output mem_write_address_o,
        output mem_write_enable_o,
        output mem_data_o,
        input  mem_ready_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_write_address_o,
        input  mem_write_enable_o,
        input  mem_data_o,
        output mem_ready_i
    );
endinterface

// File: rtl/retire_buffered.sv
// Retire stage: tag filter, write-back, traps, redirects, posted stores.
// Ports: retire bundle in, regbank/redirect/trap out, mem drain via if.
package retire_buffered_pkg;
    typedef enum logic [5:0] {
        ADD    = 6'o00,
        SUB    = 6'o01,
        LB     = 6'o10,
        LBU    = 6'o11,
        LH     = 6'o12,
        LHU    = 6'o13,
        LW     = 6'o14,
        SB     = 6'o15,
        SH     = 6'o16,
        SW     = 6'o17,
        JAL    = 6'o20,
        JALR   = 6'o21,
        BEQ    = 6'o22,
        BNE    = 6'o23,
        ECALL  = 6'o30,
        EBREAK = 6'o31,
        MRET   = 6'o32
    } iType_e;

    localparam logic [2:0] ALU_UNIT    = 3'd0;
    localparam logic [2:0] MEMORY_UNIT = 3'd1;
    localparam logic [2:0] BRANCH_UNIT = 3'd2;
    localparam logic [2:0] SYSTEM_UNIT = 3'd3;

    typedef enum logic [4:0] {
        ILLEGAL_INSTRUCTION          = 5'd2,
        BREAKPOINT                   = 5'd3,
        LOAD_ADDRESS_MISALIGNED      = 5'd4,
        STORE_AMO_ADDRESS_MISALIGNED = 5'd6,
        ECALL_FROM_MMODE             = 5'd11,
        NE                           = 5'd31
    } exceptionCode_e;
endpackage

module retire_buffered
    import retire_buffered_pkg::*;
#(
    parameter int TAG_WIDTH     = 3,
    parameter int SB_DEPTH      = 4,
    parameter int INSTRET_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic [31:0]              instruction_i,
    input  logic [31:0]              pc_i,
    input  logic [1:0][31:0]         results_i,
    input  logic [TAG_WIDTH-1:0]     tag_i,
    input  iType_e                   instruction_operation_i,
    input  logic                     write_enable_i,
    input  logic [3:0]               mem_write_enable_i,
    input  logic                     jump_i,
    input  logic                     predicted_branch_i,
    input  logic                     exception_i,
    input  logic                     interrupt_pending_i,
    input  logic [31:0]              mem_data_i,
    output logic                     stall_o,
    output logic                     killed_o,
    output logic [TAG_WIDTH-1:0]     current_retire_tag_o,
    output logic                     regbank_write_enable_o,
    output logic [31:0]              regbank_data_o,
    output logic                     jump_o,
    output logic [31:0]              jump_target_o,
    output logic                     raise_exception_o,
    output exceptionCode_e           exception_code_o,
    output logic [31:0]              exception_value_o,
    output logic                     machine_return_o,
    output logic                     interrupt_ack_o,
    retire_buffered_if.master        mem,
    output logic                     sb_empty_o,
    output logic [INSTRET_WIDTH-1:0] instret_o
);
    localparam int PW = $clog2(SB_DEPTH);

    logic [TAG_WIDTH-1:0]     curr_tag;
    logic [INSTRET_WIDTH-1:0] instret;
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [PW:0]              count;
    logic [31:0]              sb_addr [SB_DEPTH];
    logic [3:0]               sb_be   [SB_DEPTH];
    logic [31:0]              sb_data [SB_DEPTH];

    // instruction word is carried for tracing only
    logic unused_instr;
    assign unused_instr = ^instruction_i;

    iType_e      op;
    logic [31:0] addr;
    logic        killed, act, is_st, ld_mis, st_mis;
    logic        trap, full, push, pop, advance;

    assign op     = instruction_operation_i;
    assign addr   = results_i[1];
    assign killed = reset && valid_i && (tag_i != curr_tag);
    assign act    = reset && valid_i && !killed;
    assign is_st  = mem_write_enable_i != 4'b0;

    assign ld_mis = ((op == LH || op == LHU) && addr[0])
                 || (op == LW && addr[1:0] != 2'b00);
    assign st_mis = (op == SH && addr[0])
                 || (op == SW && addr[1:0] != 2'b00);

    always_comb begin
        raise_exception_o = 1'b0;
        exception_code_o  = NE;
        exception_value_o = 32'b0;
        machine_return_o  = 1'b0;
        interrupt_ack_o   = 1'b0;
        if (act) begin
            priority case (1'b1)
                exception_i: begin
                    raise_exception_o = 1'b1;
                    exception_code_o  = ILLEGAL_INSTRUCTION;
                end
                ld_mis: begin
                    raise_exception_o = 1'b1;
                    exception_code_o  = LOAD_ADDRESS_MISALIGNED;
                    exception_value_o = addr;
                end
                st_mis: begin
                    raise_exception_o = 1'b1;
                    exception_code_o  = STORE_AMO_ADDRESS_MISALIGNED;
                    exception_value_o = addr;
                end
                (op == ECALL): begin
                    raise_exception_o = 1'b1;
                    exception_code_o  = ECALL_FROM_MMODE;
                end
                (op == EBREAK): begin
                    raise_exception_o = 1'b1;
                    exception_code_o  = BREAKPOINT;
                end
                (op == MRET):        machine_return_o = 1'b1;
                interrupt_pending_i: interrupt_ack_o  = 1'b1;
                default: ;
            endcase
        end
    end

    assign trap    = raise_exception_o | machine_return_o | interrupt_ack_o;
    assign full    = count == (PW+1)'(SB_DEPTH);
    // full is judged on the registered count, so a same-cycle pop
    // does not release the stall
    assign stall_o = act && is_st && !trap && full;
    assign push    = act && is_st && !trap && !stall_o;
    assign pop     = mem.mem_req_o && mem.mem_ready_i;
    assign advance = act && !stall_o;

    // taken-but-unpredicted goes to target; predicted-but-not-taken
    // falls back to pc_i
    assign jump_o        = act && !trap && (jump_i != predicted_branch_i);
    assign jump_target_o = !jump_o ? 32'b0 : (jump_i ? addr : pc_i);

    assign killed_o               = killed;
    assign current_retire_tag_o   = curr_tag;
    assign instret_o              = instret;
    assign regbank_write_enable_o = act && write_enable_i && !trap && !stall_o;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic [31:0] ld_shift;

    assign ld_shift = mem_data_i >> {addr[1:0], 3'b000};
    assign ld_byte  = ld_shift[7:0];
    assign ld_half  = addr[1] ? mem_data_i[31:16] : mem_data_i[15:0];

    always_comb begin
        ld_fmt = mem_data_i;
        unique case (op)
            LB:      ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            LBU:     ld_fmt = {24'b0, ld_byte};
            LH:      ld_fmt = {{16{ld_half[15]}}, ld_half};
            LHU:     ld_fmt = {16'b0, ld_half};
            default: ld_fmt = mem_data_i;
        endcase
    end

    always_comb begin
        regbank_data_o = 32'b0;
        if (reset)
            regbank_data_o = (op[5:3] == MEMORY_UNIT) ? ld_fmt : results_i[0];
    end

    assign mem.mem_req_o           = count != '0;
    assign sb_empty_o              = count == '0;
    assign mem.mem_write_address_o = mem.mem_req_o ? sb_addr[rd_ptr] : 32'b0;
    assign mem.mem_write_enable_o  = mem.mem_req_o ? sb_be[rd_ptr]   : 4'b0;
    assign mem.mem_data_o          = mem.mem_req_o ? sb_data[rd_ptr] : 32'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[wr_ptr] <= {addr[31:2], 2'b00};
            sb_be[wr_ptr]   <= mem_write_enable_i;
            sb_data[wr_ptr] <= results_i[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curr_tag <= '0;
            instret  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (advance && (jump_o || trap))
                curr_tag <= curr_tag + 1'b1;
            if (advance && !raise_exception_o && !interrupt_ack_o)
                instret <= instret + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_retire_buffered.sv
// Directed bench for retire_buffered: tags, loads, traps, store drain.
// All expected values are hand-computed constants.
module tb_retire_buffered;
    import retire_buffered_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_i;
    logic [31:0]      instruction_i;
    logic [31:0]      pc_i;
    logic [1:0][31:0] results_i;
    logic [2:0]       tag_i;
    iType_e           instruction_operation_i;
    logic             write_enable_i;
    logic [3:0]       mem_write_enable_i;
    logic             jump_i;
    logic             predicted_branch_i;
    logic             exception_i;
    logic             interrupt_pending_i;
    logic [31:0]      mem_data_i;
    logic             stall_o, killed_o;
    logic [2:0]       current_retire_tag_o;
    logic             regbank_write_enable_o;
    logic [31:0]      regbank_data_o;
    logic             jump_o;
    logic [31:0]      jump_target_o;
    logic             raise_exception_o;
    exceptionCode_e   exception_code_o;
    logic [31:0]      exception_value_o;
    logic             machine_return_o, interrupt_ack_o;
    logic             sb_empty_o;
    logic [63:0]      instret_o;

    retire_buffered_if mem_bus ();

    retire_buffered #(
        .TAG_WIDTH(3), .SB_DEPTH(4), .INSTRET_WIDTH(64)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .valid_i                 (valid_i),
        .instruction_i           (instruction_i),
        .pc_i                    (pc_i),
        .results_i               (results_i),
        .tag_i                   (tag_i),
        .instruction_operation_i (instruction_operation_i),
        .write_enable_i          (write_enable_i),
        .mem_write_enable_i      (mem_write_enable_i),
        .jump_i                  (jump_i),
        .predicted_branch_i      (predicted_branch_i),
        .exception_i             (exception_i),
        .interrupt_pending_i     (interrupt_pending_i),
        .mem_data_i              (mem_data_i),
        .stall_o                 (stall_o),
        .killed_o                (killed_o),
        .current_retire_tag_o    (current_retire_tag_o),
        .regbank_write_enable_o  (regbank_write_enable_o),
        .regbank_data_o          (regbank_data_o),
        .jump_o                  (jump_o),
        .jump_target_o           (jump_target_o),
        .raise_exception_o       (raise_exception_o),
        .exception_code_o        (exception_code_o),
        .exception_value_o       (exception_value_o),
        .machine_return_o        (machine_return_o),
        .interrupt_ack_o         (interrupt_ack_o),
        .mem                     (mem_bus.master),
        .sb_empty_o              (sb_empty_o),
        .instret_o               (instret_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        valid_i                 = 1'b0;
        instruction_i           = 32'h0000_0013;
        pc_i                    = 32'b0;
        results_i               = '0;
        tag_i                   = 3'd0;
        instruction_operation_i = ADD;
        write_enable_i          = 1'b0;
        mem_write_enable_i      = 4'b0;
        jump_i                  = 1'b0;
        predicted_branch_i      = 1'b0;
        exception_i             = 1'b0;
        interrupt_pending_i     = 1'b0;
        mem_data_i              = 32'b0;
    endtask

    task automatic present(input iType_e op, input logic [2:0] tg,
                           input logic [31:0] r0, input logic [31:0] r1,
                           input logic we, input logic [3:0] mwe);
        idle();
        valid_i                 = 1'b1;
        instruction_operation_i = op;
        tag_i                   = tg;
        results_i[0]            = r0;
        results_i[1]            = r1;
        write_enable_i          = we;
        mem_write_enable_i      = mwe;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be);
        check({tag, "_addr"}, mem_bus.mem_write_address_o, a);
        check({tag, "_data"}, mem_bus.mem_data_o, d);
        check({tag, "_be"}, mem_bus.mem_write_enable_o, be);
    endtask

    initial begin
        idle();
        reset = 1'b0;
        mem_bus.mem_ready_i = 1'b0;
        repeat (2) step();

        // reset state, with a write request presented
        valid_i = 1'b1; write_enable_i = 1'b1; results_i[0] = 32'h5;
        #1;
        check("rst_we", regbank_write_enable_o, 0);
        check("rst_data", regbank_data_o, 0);
        check("rst_empty", sb_empty_o, 1);
        check("rst_req", mem_bus.mem_req_o, 0);
        check("rst_code", exception_code_o, NE);
        check("rst_instret", instret_o, 0);
        check("rst_tag", current_retire_tag_o, 0);
        check("rst_stall", stall_o, 0);
        idle();
        reset = 1'b1;
        step();

        // tag mismatch
        present(BEQ, 3'd1, 32'h0, 32'h40, 1'b1, 4'h0);
        jump_i = 1'b1;
        #1;
        check("kill", killed_o, 1);
        check("kill_we", regbank_write_enable_o, 0);
        check("kill_jump", jump_o, 0);
        step();
        check("kill_tag", current_retire_tag_o, 0);
        check("kill_instret", instret_o, 0);

        // load extraction
        present(LB, 3'd0, 32'h0, 32'h1003, 1'b1, 4'h0);
        mem_data_i = 32'h80FF_FF00;
        #1;
        check("lb", regbank_data_o, 32'hFFFF_FF80);
        check("lb_we", regbank_write_enable_o, 1);
        step();
        check("lb_instret", instret_o, 1);
        present(LBU, 3'd0, 32'h0, 32'h1003, 1'b1, 4'h0);
        mem_data_i = 32'h80FF_FF00;
        #1;
        check("lbu", regbank_data_o, 32'h0000_0080);
        step();
        present(LH, 3'd0, 32'h0, 32'h1002, 1'b1, 4'h0);
        mem_data_i = 32'h80FF_FF00;
        #1;
        check("lh", regbank_data_o, 32'hFFFF_80FF);
        step();
        present(ADD, 3'd0, 32'h1234, 32'h0, 1'b1, 4'h0);
        #1;
        check("alu", regbank_data_o, 32'h1234);
        step();
        check("alu_instret", instret_o, 4);

        // misaligned store
        present(SW, 3'd0, 32'hDEAD, 32'h1002, 1'b0, 4'hF);
        #1;
        check("sw_mis_raise", raise_exception_o, 1);
        check("sw_mis_code", exception_code_o, STORE_AMO_ADDRESS_MISALIGNED);
        check("sw_mis_val", exception_value_o, 32'h1002);
        step();
        check("sw_mis_empty", sb_empty_o, 1);
        check("sw_mis_tag", current_retire_tag_o, 1);
        check("sw_mis_instret", instret_o, 4);

        // fill buffer with memory not ready
        for (int i = 0; i < 4; i++) begin
            present(SW, 3'd1, 32'hA0 + i, 32'h100 + 4 * i, 1'b0, 4'hF);
            #1;
            check("fill_stall", stall_o, 0);
            step();
        end
        check("fill_instret", instret_o, 8);
        check("fill_req", mem_bus.mem_req_o, 1);
        check_head("head0", 32'h100, 32'hA0, 4'hF);
        present(SB, 3'd1, 32'hA4, 32'h113, 1'b0, 4'h8);
        #1;
        check("full_stall", stall_o, 1);
        step();
        check("full_instret", instret_o, 8);
        check_head("head0_hold", 32'h100, 32'hA0, 4'hF);
        mem_bus.mem_ready_i = 1'b1;
        #1;
        check("pop_stall", stall_o, 1);
        step();
        check("pop_instret", instret_o, 8);
        check("drop_stall", stall_o, 0);
        check_head("head1", 32'h104, 32'hA1, 4'hF);
        step();
        check("push_instret", instret_o, 9);
        idle();
        #1;
        check_head("head2", 32'h108, 32'hA2, 4'hF);
        step();
        check_head("head3", 32'h10C, 32'hA3, 4'hF);
        step();
        check_head("head4", 32'h110, 32'hA4, 4'h8);
        step();
        check("drain_empty", sb_empty_o, 1);
        check("drain_req", mem_bus.mem_req_o, 0);
        mem_bus.mem_ready_i = 1'b0;

        // branch recovery and redirects
        present(BEQ, 3'd1, 32'h0, 32'h300, 1'b0, 4'h0);
        predicted_branch_i = 1'b1; pc_i = 32'h200;
        #1;
        check("recov_jump", jump_o, 1);
        check("recov_tgt", jump_target_o, 32'h200);
        step();
        check("recov_tag", current_retire_tag_o, 2);
        present(BEQ, 3'd2, 32'h0, 32'h300, 1'b0, 4'h0);
        predicted_branch_i = 1'b1; jump_i = 1'b1;
        #1;
        check("pred_ok_jump", jump_o, 0);
        step();
        check("pred_ok_tag", current_retire_tag_o, 2);
        present(BNE, 3'd2, 32'h0, 32'h400, 1'b0, 4'h0);
        jump_i = 1'b1;
        #1;
        check("taken_tgt", jump_target_o, 32'h400);
        step();
        check("taken_tag", current_retire_tag_o, 3);
        check("taken_instret", instret_o, 12);

        // interrupt on a store
        present(SW, 3'd3, 32'hBEEF, 32'h300, 1'b0, 4'hF);
        interrupt_pending_i = 1'b1;
        #1;
        check("irq_ack", interrupt_ack_o, 1);
        check("irq_raise", raise_exception_o, 0);
        step();
        check("irq_empty", sb_empty_o, 1);
        check("irq_instret", instret_o, 12);
        check("irq_tag", current_retire_tag_o, 4);

        // ecall, illegal over misaligned, mret, tag wrap
        present(ECALL, 3'd4, 32'h0, 32'h0, 1'b0, 4'h0);
        #1;
        check("ecall_code", exception_code_o, ECALL_FROM_MMODE);
        step();
        present(LW, 3'd5, 32'h0, 32'h1001, 1'b1, 4'h0);
        exception_i = 1'b1;
        #1;
        check("ill_code", exception_code_o, ILLEGAL_INSTRUCTION);
        check("ill_val", exception_value_o, 0);
        check("ill_we", regbank_write_enable_o, 0);
        step();
        present(MRET, 3'd6, 32'h0, 32'h0, 1'b0, 4'h0);
        #1;
        check("mret", machine_return_o, 1);
        step();
        present(JAL, 3'd7, 32'h0, 32'h800, 1'b1, 4'h0);
        jump_i = 1'b1;
        step();
        check("wrap_tag", current_retire_tag_o, 0);
        check("wrap_instret", instret_o, 14);

        // reset during drain
        present(SW, 3'd0, 32'h1, 32'h500, 1'b0, 4'hF);
        step();
        present(SW, 3'd0, 32'h2, 32'h504, 1'b0, 4'hF);
        step();
        idle();
        check("pre_rst_instret", instret_o, 16);
        check("pre_rst_req", mem_bus.mem_req_o, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", mem_bus.mem_req_o, 0);
        check("mid_rst_empty", sb_empty_o, 1);
        check("mid_rst_instret", instret_o, 0);
        reset = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
